// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and parameter defaults for the instruction memory loader
//   state_t      : loader FSM states
//   *_DFLT       : default word width, memory depth and word-index width
package imem_loader_pkg;

    localparam int WORD_W_DFLT = 32;
    localparam int DEPTH_DFLT  = 256;
    localparam int ADDR_W_DFLT = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        RELEASE
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: control, byte stream and memory write bus of the instruction memory loader
//   master : host/stream side, drives start, num_words, abort, in_valid, in_data
//   slave  : the loader, drives in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done
interface imem_loader_if #(
    parameter int WORD_W = imem_loader_pkg::WORD_W_DFLT,
    parameter int ADDR_W = imem_loader_pkg::ADDR_W_DFLT
);

    logic              start;
    logic [ADDR_W:0]   num_words;
    logic              abort;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;

    modport master (
        output start, num_words, abort, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done
    );

    modport slave (
        input  start, num_words, abort, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done
    );

endinterface

// File: rtl/byte_packer.sv
// byte_packer: big-endian assembly of WORD_W/8 stream bytes into one word
//   clr        : drops any partial word
//   accept     : a byte is taken this cycle
//   in_data    : the byte being taken
//   word       : assembled word including the byte taken this cycle
//   word_valid : the byte taken this cycle completes a word
module byte_packer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              accept,
    input  logic [7:0]        in_data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    localparam int NB = WORD_W / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [CW-1:0]       byte_cnt;
    logic [WORD_W-9:0]   part;

    // Earlier bytes shift toward the MSBs, so the first byte lands in the top byte.
    assign word       = {part, in_data};
    assign word_valid = accept && byte_cnt == CW'(NB - 1);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            byte_cnt <= '0;
            part     <= '0;
        end else if (accept) begin
            byte_cnt <= word_valid ? '0 : byte_cnt + 1'b1;
            part     <= word[WORD_W-9:0];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams bytes into instruction memory while holding the processor in reset
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : imem_loader_if slave (start/num_words/abort control, byte stream in,
//                memory write port, cpu_rst_n, busy and done status out)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WORD_W = WORD_W_DFLT,
    parameter int DEPTH  = DEPTH_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT
) (
    input logic         clk,
    input logic         rst_n,
    imem_loader_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [ADDR_W:0]   n;
    logic [ADDR_W-1:0] word_idx;
    logic              accept;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    // abort wins over a byte offered in the same cycle
    assign accept = bus.in_valid && bus.in_ready && !bus.abort;

    byte_packer #(.WORD_W(WORD_W)) u_byte_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (state == IDLE || bus.abort),
        .accept     (accept),
        .in_data    (bus.in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // Outputs are registered from the state being entered, so they line up with state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            n             <= '0;
            word_idx      <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_rst_n <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            bus.done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    bus.cpu_rst_n <= 1'b1;
                    if (bus.start && bus.num_words != '0) begin
                        state         <= LOAD;
                        n             <= (bus.num_words > DEPTH_N) ? DEPTH_N : bus.num_words;
                        word_idx      <= '0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.cpu_rst_n <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        state         <= IDLE;
                        bus.in_ready  <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.cpu_rst_n <= 1'b1;
                    end else if (word_valid) begin
                        state         <= WRITE;
                        bus.in_ready  <= 1'b0;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= word_idx;
                        bus.mem_wdata <= word;
                    end
                end
                WRITE: begin
                    if (bus.abort) begin
                        state         <= IDLE;
                        bus.busy      <= 1'b0;
                        bus.cpu_rst_n <= 1'b1;
                    end else if ({1'b0, word_idx} + 1'b1 == n) begin
                        // last word: word_idx stays at n-1 so the address never wraps
                        state    <= RELEASE;
                        bus.done <= 1'b1;
                    end else begin
                        state        <= LOAD;
                        word_idx     <= word_idx + 1'b1;
                        bus.in_ready <= 1'b1;
                    end
                end
                RELEASE: begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.cpu_rst_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random and directed byte streams checked every cycle against a load-level model
module tb_imem_loader;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    imem_loader_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    imem_loader #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Load-level model: a load is active, collects bytes in a queue, and every fourth
    // byte becomes one write; after the n-th write comes one release cycle.
    bit          model_on = 0;
    bit          m_act = 0, m_wr = 0, m_rel = 0;
    int          m_n = 0, m_written = 0;
    logic [7:0]  m_q[$];
    bit          e_we = 0, e_done = 0, e_cpu = 0;
    logic [7:0]  e_addr = '0;
    logic [31:0] e_wdata = '0;

    always @(posedge clk) begin
        model_on = 1;
        if (!rst_n) begin
            m_act = 0; m_wr = 0; m_rel = 0; m_q.delete();
            e_we = 0; e_done = 0; e_cpu = 0; e_addr = '0; e_wdata = '0;
        end else begin
            e_we = 0;
            if (m_rel) begin
                m_rel = 0;
                m_act = 0;
            end else if (m_wr) begin
                m_wr = 0;
                if (bus.abort) m_act = 0;
                else if (m_written == m_n) m_rel = 1;
            end else if (m_act) begin
                if (bus.abort) begin
                    m_act = 0;
                    m_q.delete();
                end else if (bus.in_valid) begin
                    m_q.push_back(bus.in_data);
                    if (m_q.size() == 4) begin
                        e_we = 1;
                        e_addr = 8'(m_written);
                        e_wdata = {m_q[0], m_q[1], m_q[2], m_q[3]};
                        m_written++;
                        m_wr = 1;
                        m_q.delete();
                    end
                end
            end else if (bus.start && bus.num_words != 0) begin
                m_act = 1;
                m_n = (int'(bus.num_words) > DEPTH) ? DEPTH : int'(bus.num_words);
                m_written = 0;
                m_q.delete();
            end
            e_done = m_rel;
            e_cpu = !m_act;
        end
    end

    logic [39:0] wlog[$];
    int          dn_cnt = 0;

    always @(negedge clk) begin
        if (model_on) begin
            chk("busy", 64'(bus.busy), 64'(m_act));
            chk("in_ready", 64'(bus.in_ready), 64'(m_act && !m_wr && !m_rel));
            chk("cpu_rst_n", 64'(bus.cpu_rst_n), 64'(e_cpu));
            chk("done", 64'(bus.done), 64'(e_done));
            chk("mem_we", 64'(bus.mem_we), 64'(e_we));
            chk("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
            chk("mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata));
            if (bus.mem_we) wlog.push_back({bus.mem_addr, bus.mem_wdata});
            if (bus.done) dn_cnt++;
        end
    end

    logic [7:0] tx_q[$];

    task automatic clear_log();
        wlog.delete();
        dn_cnt = 0;
    endtask

    task automatic do_start(input logic [8:0] nw);
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_words = nw;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Offers tx_q bytes; gap<0 means random 0..3 idle cycles after each accepted byte.
    task automatic feed(input int cycles, input int gap, input int abort_at, input int stop_at);
        int   consumed = 0;
        int   wait_c = 0;
        bit   aborted = 0;
        logic rdy = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.in_valid && rdy && !bus.abort) begin
                void'(tx_q.pop_front());
                consumed++;
                wait_c = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            end
            bus.abort = 1'b0;
            bus.in_valid = 1'b0;
            if (stop_at >= 0 && consumed == stop_at) break;
            if (abort_at >= 0 && consumed == abort_at && !aborted) begin
                bus.abort = 1'b1;
                aborted = 1;
            end
            if (tx_q.size() != 0) begin
                if (wait_c > 0) wait_c--;
                else begin
                    bus.in_valid = 1'b1;
                    bus.in_data = tx_q[0];
                end
            end
            rdy = bus.in_ready;
        end
        bus.in_valid = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic push_std();
        logic [7:0] s[8] = '{8'h20, 8'h10, 8'h00, 8'h07, 8'hAC, 8'h11, 8'h00, 8'h00};
        tx_q.delete();
        foreach (s[i]) tx_q.push_back(s[i]);
    endtask

    initial begin
        bus.start = 1'b0; bus.num_words = '0; bus.abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst cpu_rst_n", 64'(bus.cpu_rst_n), 64'd0);
        chk("rst busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst release cpu_rst_n", 64'(bus.cpu_rst_n), 64'd1);

        // normal two-word load
        clear_log(); push_std();
        do_start(9'd2); feed(40, 0, -1, -1);
        chk("normal writes", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("normal w0", 64'(wlog[0]), 64'h00_20100007);
            chk("normal w1", 64'(wlog[1]), 64'h01_AC110000);
        end
        chk("normal done", 64'(dn_cnt), 64'd1);
        chk("normal cpu out of reset", 64'(bus.cpu_rst_n), 64'd1);

        // three-cycle valid gaps
        clear_log(); push_std();
        do_start(9'd2); feed(80, 3, -1, -1);
        chk("gap writes", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("gap w0", 64'(wlog[0]), 64'h00_20100007);
            chk("gap w1", 64'(wlog[1]), 64'h01_AC110000);
        end

        // abort after six bytes, then a fresh load starts at address 0
        clear_log(); tx_q.delete();
        for (int i = 0; i < 12; i++) tx_q.push_back(8'(i + 1));
        do_start(9'd3); feed(40, 0, 6, -1);
        tx_q.delete();
        chk("abort writes", 64'(wlog.size()), 64'd1);
        chk("abort done", 64'(dn_cnt), 64'd0);
        chk("abort cpu_rst_n", 64'(bus.cpu_rst_n), 64'd1);
        clear_log();
        tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_start(9'd1); feed(20, 0, -1, -1);
        chk("post-abort write", 64'(wlog.size() > 0 ? wlog[0] : 40'h0), 64'h00_DEADBEEF);

        // clamp: 300 requested, only 256 fit
        clear_log(); tx_q.delete();
        for (int i = 0; i < 1200; i++) tx_q.push_back(8'($urandom));
        do_start(9'd300); feed(1400, 0, -1, -1);
        chk("clamp writes", 64'(wlog.size()), 64'd256);
        chk("clamp last addr", 64'(wlog.size() > 0 ? wlog[$][39:32] : 8'h0), 64'd255);
        chk("clamp done", 64'(dn_cnt), 64'd1);
        chk("clamp leftover bytes", 64'(tx_q.size()), 64'd176);
        tx_q.delete();

        // ignored starts
        do_start(9'd0);
        repeat (3) @(negedge clk);
        chk("zero start busy", 64'(bus.busy), 64'd0);
        clear_log(); push_std();
        do_start(9'd2); feed(40, 0, -1, 5);
        do_start(9'd1); feed(40, 0, -1, -1);
        chk("busy start writes", 64'(wlog.size()), 64'd2);
        chk("busy start last addr", 64'(wlog.size() > 0 ? wlog[$][39:32] : 8'hFF), 64'd1);

        // reset in the middle of a load
        clear_log(); push_std();
        do_start(9'd2); feed(40, 0, -1, 5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst we", 64'(bus.mem_we), 64'd0);
        chk("midrst addr", 64'(bus.mem_addr), 64'd0);
        chk("midrst wdata", 64'(bus.mem_wdata), 64'd0);
        chk("midrst ready", 64'(bus.in_ready), 64'd0);
        chk("midrst busy", 64'(bus.busy), 64'd0);
        chk("midrst cpu", 64'(bus.cpu_rst_n), 64'd0);
        rst_n = 1'b1;
        clear_log();
        tx_q = '{8'h01, 8'h23, 8'h45, 8'h67};
        do_start(9'd1); feed(20, 0, -1, -1);
        chk("post-reset write", 64'(wlog.size() > 0 ? wlog[0] : 40'h0), 64'h00_01234567);

        // random loads with random gaps and occasional aborts
        for (int it = 0; it < 25; it++) begin
            int nw = int'($urandom_range(1, 5));
            int ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4 * nw - 1)) : -1;
            tx_q.delete();
            for (int i = 0; i < 4 * nw + 2; i++) tx_q.push_back(8'($urandom));
            do_start(9'(nw)); feed(26 * nw + 10, -1, ab, -1);
            tx_q.delete();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter WORD_W, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 256, number of instruction memory words.
REQ-003 Parameter ADDR_W, default 8, word-index width; the SHALL hold DEPTH <= 2**ADDR_W.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle pulse that begins a load.
REQ-007 num_words  input  ADDR_W+1  number of words to load; sampled only on an accepted start.
REQ-008 abort  input  1  cancels a load in progress.
REQ-009 in_valid  input  1  byte stream valid.
REQ-010 in_data  input  8  byte stream data.
REQ-011 in_ready  output  1  byte stream ready.
REQ-012 mem_we  output  1  instruction memory write enable.
REQ-013 mem_addr  output  ADDR_W  write word index, equal to byte address >> 2.
REQ-014 mem_wdata  output  WORD_W  write data.
REQ-015 cpu_rst_n  output  1  holds the processor in reset while low.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse when a load completes.

Function
REQ-018 States SHALL be IDLE, LOAD, WRITE and RELEASE.
REQ-019 IDLE -> LOAD when start=1 and num_words!=0: latch n = min(num_words, DEPTH), clear word_idx and byte_cnt.
- start with num_words=0 is ignored.
- start while busy is ignored.
REQ-020 A byte SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
- in_ready=1 only in LOAD.
- The first byte of each word fills bits [31:24]; the fourth byte fills bits [7:0] (big-endian).
REQ-021 The cycle that accepts the fourth byte SHALL move to WRITE.
REQ-022 WRITE SHALL last exactly one cycle with mem_we=1, mem_addr=word_idx and mem_wdata=assembled word.
- Then word_idx increments.
- If word_idx+1 == n, go to RELEASE; otherwise go to LOAD.
REQ-023 RELEASE SHALL last one cycle, pulse done=1, then go to IDLE.
REQ-024 cpu_rst_n SHALL be 0 in LOAD, WRITE and RELEASE, and 1 in IDLE.
- The processor therefore leaves reset on the cycle after done.
REQ-025 abort=1 in LOAD or WRITE SHALL force IDLE on the next edge.
- A WRITE cycle in which abort is sampled still has mem_we=1 for that cycle.
- Partial words are discarded.
- done is not pulsed.
- abort has priority over a byte acceptance in the same cycle.
REQ-026 word_idx SHALL never exceed n-1, so mem_addr never wraps past DEPTH-1.
REQ-027 mem_addr and mem_wdata SHALL be registered and hold their last values when mem_we=0.
REQ-028 Gaps in in_valid SHALL stall assembly indefinitely without timeout or data loss.

Reset
REQ-029 With rst_n=0 at a clock edge, the following SHALL be forced:
- state=IDLE, word_idx=0, byte_cnt=0.
- mem_addr=0, mem_wdata=0, mem_we=0, in_ready=0, busy=0, done=0.
- cpu_rst_n=0 while rst_n=0, and 1 from the first cycle after release.
REQ-030 Reset mid-load SHALL discard all progress; words already written remain in memory.

Structure
REQ-031 Package imem_loader_pkg SHALL hold the state enum and the WORD_W, DEPTH and ADDR_W defaults.
REQ-032 Sub-module byte_packer SHALL perform 4-byte big-endian assembly, with byte_cnt and a word_valid strobe; the FSM stays in imem_loader.

Verification
REQ-033 Normal load: start, num_words=2, bytes 20 10 00 07 AC 11 00 00 -> writes 0x20100007 at addr 0 and 0xAC110000 at addr 1, one done pulse, cpu_rst_n low from the cycle after start through RELEASE.
REQ-034 Valid gaps: same stream with in_valid low for 3 cycles between every byte -> identical writes, and no write before the 4th byte of each word.
REQ-035 Abort: num_words=3, abort after 6 bytes -> exactly one write (addr 0), no done, cpu_rst_n=1 on the next cycle, and a following start loads from addr 0.
REQ-036 Clamp: num_words=300 with 1200 bytes offered -> 256 writes at addr 0..255, then done, and in_ready=0 for the remaining bytes.
REQ-037 Ignored starts: num_words=0 -> busy stays 0; a start while busy -> no restart, and word_idx continues.
REQ-038 Reset mid-load: rst_n=0 for 1 cycle after 5 bytes -> all outputs at reset values, and a subsequent load of 1 word writes addr 0.
